q2a03_phase_gen: RTL and testbench



---
 rtl/q2a03_phase_gen.sv | 115 +++++++++++
 tb/tb_q2a03_phase_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/q2a03_phase_gen.sv
// rtl/q2a03_phase_gen.sv - programmable M-cycle divider, phase strobes and interrupt capture
// Ticks 0..div_cur-1 per M-cycle; phy2 is high from at_cur to the end of the cycle.
module q2a03_phase_gen #(
  parameter int DIV_W       = 5,
  parameter int DEF_DIV     = 12,
  parameter int DEF_PHY2_AT = 6,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             G_clock,
  input  logic             G_reset,
  input  logic             G_ready,
  input  logic [DIV_W-1:0] G_div,
  input  logic [DIV_W-1:0] G_phy2_at,
  input  logic             G_nmi,
  input  logic             G_irq,
  input  logic             G_nmi_ack,
  output logic [DIV_W-1:0] G_tick,
  output logic             G_phy1,
  output logic             G_phy2,
  output logic             G_edge_rise,
  output logic             G_edge_fall,
  output logic [CNT_W-1:0] G_mcycle,
  output logic             G_nmi_pend,
  output logic             G_irq_pend
);

  localparam logic [DIV_W-1:0] L_DEF_DIV = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] L_DEF_AT  = DIV_W'(DEF_PHY2_AT);

  logic [DIV_W-1:0]       r_tick;
  logic [DIV_W-1:0]       r_div_cur;
  logic [DIV_W-1:0]       r_at_cur;
  logic                   r_started;
  logic [CNT_W-1:0]       r_mcycle;
  logic [SYNC_STAGES-1:0] r_nmi_sync;
  logic [SYNC_STAGES-1:0] r_irq_sync;
  logic                   r_nmi_last;
  logic                   r_nmi_pend;
  logic                   r_irq_pend;

  logic w_last;
  logic w_req_ok;
  logic w_phy2;
  logic w_rise;
  logic w_fall;
  logic w_nmi_fall;

  assign w_last     = (r_tick == (r_div_cur - DIV_W'(1)));
  assign w_req_ok   = (G_div >= DIV_W'(2)) && (G_phy2_at != '0) && (G_phy2_at < G_div);
  assign w_phy2     = r_started && (r_tick >= r_at_cur);
  assign w_rise     = G_ready && r_started && (r_tick == r_at_cur);
  assign w_fall     = G_ready && r_started && w_last;
  assign w_nmi_fall = r_nmi_last && !r_nmi_sync[SYNC_STAGES-1];

  // Tick starts at DEF_DIV-1, so the first ready clock after reset is a normal wrap.
  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      r_tick    <= L_DEF_DIV - DIV_W'(1);
      r_div_cur <= L_DEF_DIV;
      r_at_cur  <= L_DEF_AT;
      r_started <= 1'b0;
    end else if (G_ready) begin
      if (w_last) begin
        r_tick    <= '0;
        r_started <= 1'b1;
        r_div_cur <= w_req_ok ? G_div     : L_DEF_DIV;
        r_at_cur  <= w_req_ok ? G_phy2_at : L_DEF_AT;
      end else begin
        r_tick <= r_tick + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      r_mcycle <= '0;
    end else if (w_fall) begin
      r_mcycle <= r_mcycle + CNT_W'(1);
    end
  end

  // Synchronisers idle high; r_nmi_last adds the edge-detect stage.
  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      r_nmi_sync <= '1;
      r_irq_sync <= '1;
      r_nmi_last <= 1'b1;
      r_nmi_pend <= 1'b0;
      r_irq_pend <= 1'b0;
    end else begin
      r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], G_nmi};
      r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], G_irq};
      r_nmi_last <= r_nmi_sync[SYNC_STAGES-1];
      if (w_nmi_fall) begin
        r_nmi_pend <= 1'b1;
      end else if (G_nmi_ack) begin
        r_nmi_pend <= 1'b0;
      end
      if (w_rise) begin
        r_irq_pend <= !r_irq_sync[SYNC_STAGES-1];
      end
    end
  end

  assign G_tick      = r_tick;
  assign G_phy2      = w_phy2;
  assign G_phy1      = r_started && !w_phy2;
  assign G_edge_rise = w_rise;
  assign G_edge_fall = w_fall;
  assign G_mcycle    = r_mcycle;
  assign G_nmi_pend  = r_nmi_pend;
  assign G_irq_pend  = r_irq_pend;

endmodule

// File: tb/tb_q2a03_phase_gen.sv
// tb/tb_q2a03_phase_gen.sv - scoreboard bench for q2a03_phase_gen against a cycle-position model
module tb_q2a03_phase_gen;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ready = 1'b1;
  logic [4:0] div = 5'd12;
  logic [4:0] phy2_at = 5'd6;
  logic       nmi = 1'b1;
  logic       irq = 1'b1;
  logic       nmi_ack = 1'b0;
  logic [4:0] tick;
  logic       phy1, phy2, rise, fall, nmi_pend, irq_pend;
  logic [3:0] mcycle;

  q2a03_phase_gen #(.DIV_W(5), .DEF_DIV(12), .DEF_PHY2_AT(6), .CNT_W(4), .SYNC_STAGES(S)) dut (
    .G_clock(clk), .G_reset(rstn), .G_ready(ready), .G_div(div), .G_phy2_at(phy2_at),
    .G_nmi(nmi), .G_irq(irq), .G_nmi_ack(nmi_ack), .G_tick(tick), .G_phy1(phy1),
    .G_phy2(phy2), .G_edge_rise(rise), .G_edge_fall(fall), .G_mcycle(mcycle),
    .G_nmi_pend(nmi_pend), .G_irq_pend(irq_pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] tick;
    logic       phy1;
    logic       phy2;
    logic       rise;
    logic       fall;
    logic [3:0] mc;
    logic       np;
    logic       ip;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_step = 0;

  // Model: position within the current M-cycle, its length and phy2 start.
  int m_pos, m_len, m_at, m_mc;
  bit m_started, m_np, m_ip;
  int nh[$];
  int ih[$];

  function automatic bit cfg_legal(input int dv, input int at);
    return (dv >= 2) && (at != 0) && (at < dv);
  endfunction

  task automatic model_reset();
    m_pos = 11; m_len = 12; m_at = 6; m_mc = 0;
    m_started = 0; m_np = 0; m_ip = 0;
    nh.delete(); ih.delete();
    for (int i = 0; i < S + 1; i++) begin
      nh.push_back(1);
      ih.push_back(1);
    end
  endtask

  task automatic step(input bit rdy, input int dv, input int at, input bit n, input bit q,
                      input bit ack, input bit rn);
    obs_t e;
    bit   r, f, set;
    @(posedge clk);
    #1;
    ready = rdy; div = 5'(dv); phy2_at = 5'(at); nmi = n; irq = q; nmi_ack = ack; rstn = rn;
    n_step++;
    if (!rn) model_reset();
    r = rdy && m_started && (m_pos == m_at);
    f = rdy && m_started && (m_pos == m_len - 1);
    e.tick = 5'(m_pos);
    e.phy2 = m_started && (m_pos >= m_at);
    e.phy1 = m_started && !(m_pos >= m_at);
    e.rise = r;
    e.fall = f;
    e.mc   = 4'(m_mc);
    e.np   = m_np;
    e.ip   = m_ip;
    exp_q.push_back(e);
    if (rn) begin
      nh.push_back(n);
      ih.push_back(q);
      set = (nh[nh.size()-S-2] == 1) && (nh[nh.size()-S-1] == 0);
      if (set) m_np = 1;
      else if (ack) m_np = 0;
      if (r) m_ip = !ih[ih.size()-1-S][0];
      if (f) m_mc = (m_mc + 1) % 16;
      if (rdy) begin
        if (m_pos == m_len - 1) begin
          m_pos = 0;
          m_started = 1;
          if (cfg_legal(dv, at)) begin m_len = dv; m_at = at; end
          else begin m_len = 12; m_at = 6; end
        end else begin
          m_pos++;
        end
      end
      while (nh.size() > S + 2) begin void'(nh.pop_front()); void'(ih.pop_front()); end
    end
  endtask

  task automatic run_to(input int pos, input int dv, input int at);
    int guard = 0;
    while (!(m_started && m_pos == pos) && guard < 64) begin
      step(1, dv, at, 1, 1, 0, 1);
      guard++;
    end
    if (guard >= 64) begin
      n_err++;
      $display("FAIL run_to: tick %0d not reached, got pos %0d", pos, m_pos);
    end
  endtask

  always @(negedge clk) begin
    obs_t got, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = '{tick, phy1, phy2, rise, fall, mcycle, nmi_pend, irq_pend};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL outputs step %0d: got tick=%0d p1=%b p2=%b rise=%b fall=%b mc=%0d np=%b ip=%b, expected tick=%0d p1=%b p2=%b rise=%b fall=%b mc=%0d np=%b ip=%b",
                 n_vec, got.tick, got.phy1, got.phy2, got.rise, got.fall, got.mc, got.np, got.ip,
                 e.tick, e.phy1, e.phy2, e.rise, e.fall, e.mc, e.np, e.ip);
      end
    end
  end

  initial begin
    int dv, at;
    bit n, q;
    model_reset();
    repeat (3) step(1, 12, 6, 1, 1, 0, 0);
    // Default timing with a short stall at tick 8.
    repeat (37) step(1, 12, 6, 1, 1, 0, 1);
    run_to(8, 12, 6);
    repeat (5) step(0, 12, 6, 1, 1, 0, 1);
    repeat (20) step(1, 12, 6, 1, 1, 0, 1);
    // Mid-cycle reconfiguration to PAL timing.
    run_to(4, 12, 6);
    repeat (30) step(1, 16, 8, 1, 1, 0, 1);
    // Illegal requests fall back to defaults.
    run_to(15, 1, 6);
    repeat (14) step(1, 10, 10, 1, 1, 0, 1);
    repeat (14) step(1, 15, 7, 1, 0, 0, 1);
    // NMI: ack coincides with set, then ack, then held low.
    step(1, 12, 6, 0, 1, 0, 1);
    step(1, 12, 6, 1, 1, 0, 1);
    step(1, 12, 6, 1, 1, 1, 1);
    repeat (3) step(1, 12, 6, 1, 1, 0, 1);
    step(1, 12, 6, 1, 1, 1, 1);
    repeat (5) step(1, 12, 6, 0, 1, 0, 1);
    step(1, 12, 6, 0, 1, 1, 1);
    repeat (95) step(1, 12, 6, 0, 1, 0, 1);
    repeat (5) step(1, 12, 6, 1, 1, 0, 1);
    // Counter wrap, then reset at tick 7.
    repeat (200) step(1, 12, 6, 1, 1, 0, 1);
    run_to(7, 12, 6);
    step(1, 12, 6, 1, 1, 0, 0);
    step(1, 12, 6, 1, 1, 0, 0);
    repeat (20) step(1, 12, 6, 1, 1, 0, 1);
    // Randomized traffic.
    dv = 12; at = 6; n = 1; q = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        dv = $urandom_range(0, 31);
        at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(1, (dv > 1) ? dv - 1 : 1);
      end
      if ($urandom_range(0, 9) == 0) n = !n;
      if ($urandom_range(0, 14) == 0) q = !q;
      step($urandom_range(0, 7) != 0, dv, at, n, q, $urandom_range(0, 5) == 0,
           $urandom_range(0, 499) != 0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
